aes_mode_ctrl: RTL
==================

Name: aes_mode_ctrl

Overview:
Request sequencer that sits in front of the paired aes_cipher_top / aes_inv_cipher_top cores. It accepts one encrypt or decrypt job per valid/ready handshake and drives the matching core's load strobes, including the inverse-cipher key-load and key-expansion wait. It returns the result on a valid/ready response port and guarantees the two cores are never loaded in the same cycle. A watchdog converts a missing done into an error response.

Parameters:
KEXP_CYCLES, 10, cycles to wait after dec_kld before dec_ld is allowed (key expansion); legal range 1..255.
TIMEOUT, 64, max BUSY cycles without done before an error response; 0 disables the watchdog.

Ports:
clk  in  1  clock; all logic on the rising edge.
rst  in  1  synchronous, active-high reset.
req_valid  in  1  job request.
req_ready  out  1  controller can accept a job.
req_mode  in  1  0 = encrypt, 1 = decrypt.
req_key  in  128  cipher key.
req_text  in  128  plaintext or ciphertext.
resp_valid  out  1  result available.
resp_ready  in  1  consumer accepts result.
resp_text  out  128  result block.
resp_mode  out  1  mode of the returned job.
resp_err  out  1  1 = watchdog timeout; resp_text is 0 in that case.
busy  out  1  high in any state other than IDLE.
enc_ld  out  1  cipher load strobe.
enc_done  in  1  cipher done.
enc_text_out  in  128  cipher result.
dec_kld  out  1  inverse-cipher key-load strobe.
dec_ld  out  1  inverse-cipher load strobe.
dec_done  in  1  inverse-cipher done.
dec_text_out  in  128  inverse-cipher result.
core_key  out  128  key bus shared by both cores.
core_text  out  128  text bus shared by both cores.

Behaviour:
- Reset (synchronous): state = IDLE; all outputs are 0, including req_ready in the reset cycle; the key/text/result registers clear; the key cache is invalidated. A reset asserted in any state aborts the job, and no response is produced.
- core_key and core_text come from registers latched at acceptance. They stay stable until the next acceptance.
- IDLE: req_ready = 1. When req_valid && req_ready, latch mode, key and text.
  - Encrypt goes to LOAD.
  - Decrypt goes to KLOAD, or to LOAD on a cache hit (see Optional Feature).
- KLOAD: dec_kld = 1 for exactly one cycle. Load the counter with KEXP_CYCLES, then go to KWAIT.
- KWAIT: decrement once per cycle. When the counter reaches 0, go to LOAD, so the wait is exactly KEXP_CYCLES cycles.
- LOAD: pulse enc_ld or dec_ld for exactly one cycle, chosen by the latched mode. Clear the watchdog, then go to BUSY.
- BUSY:
  - Sample only the selected core's done; the other core's done is ignored.
  - On done in cycle N: capture that core's text_out into resp_text, set resp_mode, clear resp_err, and drive resp_valid = 1 from cycle N+1 in HOLD.
  - If TIMEOUT != 0 and TIMEOUT BUSY cycles pass without done: resp_err = 1, resp_text = 0, invalidate the cache, go to HOLD.
  - Done has priority over timeout when both occur in the same cycle.
- HOLD: resp_valid, resp_text, resp_mode and resp_err stay stable until resp_ready. On the handshake cycle go to IDLE; req_ready rises the next cycle. There is no request/response overlap.
- Invariants:
  - enc_ld, dec_ld and dec_kld are one-hot or all-zero, and each is a single-cycle pulse.
  - done inputs outside BUSY are ignored.
- Latency (encrypt): accept in cycle 0, enc_ld in cycle 1, BUSY from cycle 2.

Optional Feature:
AES_KEY_CACHE_EN:
- Defined: a 128-bit last-key register plus a valid bit, written in KLOAD.
  - A decrypt request whose key equals the cached key while the valid bit is set goes IDLE -> LOAD, skipping KLOAD and KWAIT.
  - Encrypt jobs do not touch the cache.
  - Reset and timeout clear the valid bit.
- Undefined: every decrypt job passes through KLOAD and KWAIT, and there is no cache register.

Test Plan:
1. Encrypt, key 000102030405060708090a0b0c0d0e0f, text 00112233445566778899aabbccddeeff, core model asserts done 12 cycles after ld -> enc_ld single pulse in cycle 1, no dec strobes, resp_text 69c4e0d86a7b0430d8cdb78070b4c55a, resp_mode 0, resp_err 0.
2. Decrypt, same key, text 69c4e0d86a7b0430d8cdb78070b4c55a, KEXP_CYCLES = 10 -> dec_kld in cycle 1, dec_ld in cycle 12, resp_text 00112233445566778899aabbccddeeff, resp_mode 1.
3. Hold resp_ready low for 5 cycles after resp_valid, with a second req_valid pending -> response fields stable, req_ready 0, second job accepted only in the cycle after the response handshake.
4. TIMEOUT = 32, core never asserts done -> resp_valid in cycle 34 with resp_err 1 and resp_text 0.
5. Assert rst in cycle 5 of BUSY -> next cycle all outputs 0, no response; after rst deasserts, a new encrypt completes normally.
6. Two back-to-back decrypts with the same key -> with AES_KEY_CACHE_EN, exactly one dec_kld pulse and the second dec_ld one cycle after acceptance; without the macro, two dec_kld pulses.

Source files
------------

// File: rtl/aes_mode_ctrl.sv
// Job sequencer for the aes_cipher_top / aes_inv_cipher_top pair: load strobes, key-expansion wait, watchdog.
// Optional last-key cache for decrypt jobs: define AES_KEY_CACHE_EN.
module aes_mode_ctrl #(
    parameter int KEXP_CYCLES = 10,
    parameter int TIMEOUT     = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic         req_mode,
    input  logic [127:0] req_key,
    input  logic [127:0] req_text,
    output logic         resp_valid,
    input  logic         resp_ready,
    output logic [127:0] resp_text,
    output logic         resp_mode,
    output logic         resp_err,
    output logic         busy,
    output logic         enc_ld,
    input  logic         enc_done,
    input  logic [127:0] enc_text_out,
    output logic         dec_kld,
    output logic         dec_ld,
    input  logic         dec_done,
    input  logic [127:0] dec_text_out,
    output logic [127:0] core_key,
    output logic [127:0] core_text
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_KLOAD = 3'd1;
    localparam logic [2:0] S_KWAIT = 3'd2;
    localparam logic [2:0] S_LOAD  = 3'd3;
    localparam logic [2:0] S_BUSY  = 3'd4;
    localparam logic [2:0] S_HOLD  = 3'd5;

    logic [2:0]   state;
    logic         rdy;
    logic         mode_r;
    logic [127:0] key_r;
    logic [127:0] text_r;
    logic [7:0]   kcnt;
    logic [31:0]  wd;
    logic [127:0] res_text;
    logic         res_mode;
    logic         res_err;
    logic         sel_done;
    logic [127:0] sel_text;
    logic         timeout_hit;
    logic         accept;
    logic         hit;

    assign accept      = (state == S_IDLE) && rdy && req_valid;
    assign sel_done    = mode_r ? dec_done : enc_done;
    assign sel_text    = mode_r ? dec_text_out : enc_text_out;
    assign timeout_hit = (TIMEOUT != 0) && (wd == 32'(TIMEOUT - 1));

`ifdef AES_KEY_CACHE_EN
    logic [127:0] cache_key;
    logic         cache_vld;

    assign hit = cache_vld && (req_key == cache_key);

    always_ff @(posedge clk) begin
        if (rst) begin
            cache_key <= '0;
            cache_vld <= 1'b0;
        end else if (state == S_KLOAD) begin
            cache_key <= key_r;
            cache_vld <= 1'b1;
        end else if (state == S_BUSY && !sel_done && timeout_hit) begin
            cache_vld <= 1'b0;
        end
    end
`else
    assign hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            rdy      <= 1'b0;
            mode_r   <= 1'b0;
            key_r    <= '0;
            text_r   <= '0;
            kcnt     <= '0;
            wd       <= '0;
            res_text <= '0;
            res_mode <= 1'b0;
            res_err  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    // req_ready stays low for one cycle after reset, then follows IDLE
                    if (accept) begin
                        rdy    <= 1'b0;
                        mode_r <= req_mode;
                        key_r  <= req_key;
                        text_r <= req_text;
                        state  <= (req_mode && !hit) ? S_KLOAD : S_LOAD;
                    end else begin
                        rdy <= 1'b1;
                    end
                end
                S_KLOAD: begin
                    kcnt  <= 8'(KEXP_CYCLES);
                    state <= S_KWAIT;
                end
                S_KWAIT: begin
                    kcnt <= kcnt - 8'd1;
                    if (kcnt == 8'd1) state <= S_LOAD;
                end
                S_LOAD: begin
                    wd    <= '0;
                    state <= S_BUSY;
                end
                S_BUSY: begin
                    // done wins over a coincident timeout
                    if (sel_done) begin
                        res_text <= sel_text;
                        res_mode <= mode_r;
                        res_err  <= 1'b0;
                        state    <= S_HOLD;
                    end else if (timeout_hit) begin
                        res_text <= '0;
                        res_mode <= mode_r;
                        res_err  <= 1'b1;
                        state    <= S_HOLD;
                    end else begin
                        wd <= wd + 32'd1;
                    end
                end
                S_HOLD: begin
                    if (resp_ready) begin
                        rdy   <= 1'b1;
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign req_ready  = rdy;
    assign busy       = (state != S_IDLE);
    assign dec_kld    = (state == S_KLOAD);
    assign enc_ld     = (state == S_LOAD) && !mode_r;
    assign dec_ld     = (state == S_LOAD) && mode_r;
    assign resp_valid = (state == S_HOLD);
    assign resp_text  = res_text;
    assign resp_mode  = res_mode;
    assign resp_err   = res_err;
    assign core_key   = key_r;
    assign core_text  = text_r;

endmodule
